// File: rtl/ram_pdp_frame_reader_if.sv
// Pixel stream bundle from the frame reader to the colour-map/display path:
// valid/ready handshake plus start-of-frame, end-of-line and end-of-frame markers.
interface ram_pdp_frame_reader_if #(
    parameter int DATA_W = 18
);
    logic [DATA_W-1:0] data;
    logic              valid;
    logic              ready;
    logic              sof;
    logic              eol;
    logic              eof;

    modport master (output data, valid, sof, eol, eof, input ready);
    modport slave  (input data, valid, sof, eol, eof, output ready);
endinterface

// File: rtl/ram_pdp_frame_reader.sv
// Read-side frame engine for the simple-dual-port block RAM wrapper.
// Walks one frame in raster order on the RAM read port, tracks read latency
// with a tag pipeline and delivers pixels through a small output FIFO.
// Optional build macro RAM_PDP_READER_SCALE2X_EN: 2x upscaled output (every
// line read twice, every FIFO entry presented twice).
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for start, RAM read port disabled
// RUN    | issuing raster addresses while FIFO + in-flight has room
// DRAIN  | all addresses issued, waiting for the last pixel to leave
module ram_pdp_frame_reader #(
    parameter int ADDR_W     = 14,
    parameter int DATA_W     = 18,
    parameter int FRAME_W    = 32,
    parameter int FRAME_H    = 24,
    parameter int BASE_ADDR  = 0,
    parameter int RD_LATENCY = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  ram_clk_en,
    output logic [ADDR_W-1:0]     ram_addr,
    input  logic [DATA_W-1:0]     ram_rd_data,
    ram_pdp_frame_reader_if.master m
);

    localparam int X_W   = (FRAME_W > 1) ? $clog2(FRAME_W) : 1;
    localparam int Y_W   = (FRAME_H > 1) ? $clog2(FRAME_H) : 1;
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    localparam logic [X_W-1:0]    X_LAST    = X_W'(FRAME_W - 1);
    localparam logic [Y_W-1:0]    Y_LAST    = Y_W'(FRAME_H - 1);
    localparam logic [ADDR_W-1:0] ADDR_BASE = ADDR_W'(BASE_ADDR);
    localparam logic [CNT_W-1:0]  CNT_DEPTH = CNT_W'(FIFO_DEPTH);
    localparam logic [PTR_W-1:0]  PTR_LAST  = PTR_W'(FIFO_DEPTH - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    logic [1:0]       state;
    logic [X_W-1:0]   x;
    logic [Y_W-1:0]   y;
    // occ counts FIFO entries plus reads still in flight in the tag pipeline
    logic [CNT_W-1:0] occ;
    logic [CNT_W-1:0] occ_n;
    logic [CNT_W-1:0] fifo_count;
    logic [CNT_W-1:0] fifo_count_n;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    // tag layout: {valid, sof, eol, eof}
    logic [3:0]          tag_pipe [RD_LATENCY];
    logic [3:0]          tag_in;
    logic [DATA_W+2:0]   fifo_mem [FIFO_DEPTH];
    logic [DATA_W+2:0]   head;

    logic issue, last_x, last_pix, t_sof, t_eof;
    logic cap, xfer, pop, finish;

`ifdef RAM_PDP_READER_SCALE2X_EN
    logic              pass;
    logic              copy;
    logic [ADDR_W-1:0] line_addr;
`endif

    // Issue decision, tag generation and FIFO/occupancy bookkeeping
    always_comb begin
        last_x = (x == X_LAST);
`ifdef RAM_PDP_READER_SCALE2X_EN
        t_sof    = (x == '0) && (y == '0) && !pass;
        t_eof    = last_x && (y == Y_LAST) && pass;
`else
        t_sof    = (x == '0) && (y == '0);
        t_eof    = last_x && (y == Y_LAST);
`endif
        last_pix = t_eof;
        issue    = (state == S_RUN) && (occ < CNT_DEPTH);
        tag_in   = issue ? {1'b1, t_sof, last_x, t_eof} : 4'b0000;
        cap      = tag_pipe[RD_LATENCY-1][3];
        xfer     = m.valid && m.ready;
`ifdef RAM_PDP_READER_SCALE2X_EN
        pop      = xfer && copy;
`else
        pop      = xfer;
`endif
        fifo_count_n = fifo_count + CNT_W'(cap) - CNT_W'(pop);
        occ_n        = occ + CNT_W'(issue) - CNT_W'(pop);
        finish       = (state == S_DRAIN) && (occ_n == '0);
    end

    // Stream outputs straight from the FIFO head; flags only meaningful with valid
    always_comb begin
        head    = fifo_mem[rd_ptr];
        m.valid = (fifo_count != '0);
        m.data  = head[DATA_W+2:3];
`ifdef RAM_PDP_READER_SCALE2X_EN
        m.sof   = m.valid && head[2] && !copy;
        m.eol   = m.valid && head[1] && copy;
        m.eof   = m.valid && head[0] && copy;
`else
        m.sof   = m.valid && head[2];
        m.eol   = m.valid && head[1];
        m.eof   = m.valid && head[0];
`endif
    end

    assign ram_clk_en = busy;

    // Frame FSM, raster counters and RAM address generation
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            x        <= '0;
            y        <= '0;
            ram_addr <= ADDR_BASE;
            occ      <= '0;
`ifdef RAM_PDP_READER_SCALE2X_EN
            pass      <= 1'b0;
            line_addr <= ADDR_BASE;
`endif
        end else begin
            done <= 1'b0;
            occ  <= occ_n;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state    <= S_RUN;
                        busy     <= 1'b1;
                        x        <= '0;
                        y        <= '0;
                        ram_addr <= ADDR_BASE;
`ifdef RAM_PDP_READER_SCALE2X_EN
                        pass      <= 1'b0;
                        line_addr <= ADDR_BASE;
`endif
                    end
                end
                S_RUN: begin
                    if (issue) begin
                        if (last_pix) state <= S_DRAIN;
                        if (last_x) begin
                            x <= '0;
`ifdef RAM_PDP_READER_SCALE2X_EN
                            // first pass of a line rewinds to re-read it
                            if (!pass) begin
                                pass     <= 1'b1;
                                ram_addr <= line_addr;
                            end else begin
                                pass      <= 1'b0;
                                y         <= y + Y_W'(1);
                                ram_addr  <= ram_addr + ADDR_W'(1);
                                line_addr <= ram_addr + ADDR_W'(1);
                            end
`else
                            y        <= y + Y_W'(1);
                            ram_addr <= ram_addr + ADDR_W'(1);
`endif
                        end else begin
                            x        <= x + X_W'(1);
                            ram_addr <= ram_addr + ADDR_W'(1);
                        end
                    end
                end
                S_DRAIN: begin
                    if (finish) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Tag shift register mirrors the RAM read latency
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < RD_LATENCY; i++) tag_pipe[i] <= 4'b0000;
        end else begin
            tag_pipe[0] <= tag_in;
            for (int i = 1; i < RD_LATENCY; i++) tag_pipe[i] <= tag_pipe[i-1];
        end
    end

    // FIFO pointers, count and duplicate-copy phase
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
`ifdef RAM_PDP_READER_SCALE2X_EN
            copy       <= 1'b0;
`endif
        end else begin
            fifo_count <= fifo_count_n;
            if (cap) wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PTR_W'(1);
            if (pop) rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + PTR_W'(1);
`ifdef RAM_PDP_READER_SCALE2X_EN
            if (xfer) copy <= !copy;
`endif
        end
    end

    // FIFO storage: returned RAM word plus its flags, written as the tag emerges
    always_ff @(posedge clk) begin
        if (cap) fifo_mem[wr_ptr] <= {ram_rd_data, tag_pipe[RD_LATENCY-1][2:0]};
    end

endmodule

// File: tb/tb_ram_pdp_frame_reader.sv
// Bench for ram_pdp_frame_reader: two instances (base 0, 4x2 frame; base
// 16382, 4x1 frame crossing the address wrap), each with a RAM model that
// returns its address as data with a 2-cycle read latency.
module tb_ram_pdp_frame_reader;

`ifdef RAM_PDP_READER_SCALE2X_EN
    localparam int SC = 2;
`else
    localparam int SC = 1;
`endif
    localparam int A_PIX = 4 * 2 * SC * SC;
    localparam int B_PIX = 4 * 1 * SC * SC;

    typedef logic [20:0] pix_t;

    logic clk, rst_n;
    logic start_a, busy_a, done_a, ram_clk_en_a;
    logic start_b, busy_b, done_b, ram_clk_en_b;
    logic [13:0] ram_addr_a, ram_addr_b, ra_q, rb_q;
    logic [17:0] ram_rd_data_a, ram_rd_data_b;

    int total = 0;
    int bad   = 0;

    ram_pdp_frame_reader_if #(.DATA_W(18)) pa ();
    ram_pdp_frame_reader_if #(.DATA_W(18)) pb ();

    ram_pdp_frame_reader #(.ADDR_W(14), .DATA_W(18), .FRAME_W(4), .FRAME_H(2),
        .BASE_ADDR(0), .RD_LATENCY(2), .FIFO_DEPTH(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .busy(busy_a), .done(done_a),
        .ram_clk_en(ram_clk_en_a), .ram_addr(ram_addr_a), .ram_rd_data(ram_rd_data_a), .m(pa));

    ram_pdp_frame_reader #(.ADDR_W(14), .DATA_W(18), .FRAME_W(4), .FRAME_H(1),
        .BASE_ADDR(16382), .RD_LATENCY(2), .FIFO_DEPTH(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .busy(busy_b), .done(done_b),
        .ram_clk_en(ram_clk_en_b), .ram_addr(ram_addr_b), .ram_rd_data(ram_rd_data_b), .m(pb));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM models: address register then output register, content = address
    always @(posedge clk) begin
        if (ram_clk_en_a) begin ra_q <= ram_addr_a; ram_rd_data_a <= {4'b0, ra_q}; end
        if (ram_clk_en_b) begin rb_q <= ram_addr_b; ram_rd_data_b <= {4'b0, rb_q}; end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Expected output pixel number idx of a frame, from raster arithmetic alone
    function automatic pix_t exp_pix(input int base, input int w, input int h, input int idx);
        int ow, line, col, yy, xx, addr;
        logic sof, eol, eof;
        ow   = w * SC;
        line = idx / ow;
        col  = idx % ow;
        yy   = line / SC;
        xx   = col / SC;
        addr = (base + yy * w + xx) % 16384;
        sof  = (idx == 0);
        eol  = (col == ow - 1);
        eof  = (idx == w * h * SC * SC - 1);
        return {18'(addr), sof, eol, eof};
    endfunction

    // Per-cycle scoreboard for instance A
    int a_idx = 0, a_total = 0;
    bit a_busy = 0, a_done = 0;
    always @(negedge clk) begin
        bit was_busy;
        pix_t e;
        if (!rst_n) begin
            a_idx = 0; a_total = 0; a_busy = 0; a_done = 0;
        end else begin
            chk("a_busy", busy_a, a_busy);
            chk("a_done", done_a, a_done);
            chk("a_clk_en", ram_clk_en_a, a_busy);
            if (pa.valid) begin
                if (a_idx >= a_total) begin
                    total++; bad++;
                    $display("FAIL a_extra_pixel: got data %0d expected no pixel", pa.data);
                end else begin
                    e = exp_pix(0, 4, 2, a_idx);
                    chk("a_data", pa.data, e[20:3]);
                    chk("a_sof", pa.sof, e[2]);
                    chk("a_eol", pa.eol, e[1]);
                    chk("a_eof", pa.eof, e[0]);
                end
            end
            if (dut_a.cap)
                chk("a_fifo_full_at_capture", (dut_a.fifo_count == 4) && !dut_a.pop, 0);
            was_busy = a_busy;
            a_done = 0;
            if (pa.valid && pa.ready && a_idx < a_total) begin
                a_idx++;
                if (a_idx == a_total) begin a_done = 1; a_busy = 0; end
            end
            if (start_a && !was_busy) begin a_idx = 0; a_total = A_PIX; a_busy = 1; end
        end
    end

    task automatic pulse_start_a();
        @(posedge clk); #2 start_a = 1;
        @(posedge clk); #2 start_a = 0;
    endtask

    task automatic wait_idle_a(input string name);
        int c;
        for (c = 0; c < 300; c++) begin
            @(negedge clk);
            if (!busy_a && !pa.valid) break;
        end
        chk(name, c < 300, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_x, n_done, k, bi;
        int b_lit [8];
        int b_nlit;
        bit exp_v;
        pix_t e;

        rst_n = 0; start_a = 0; start_b = 0; pa.ready = 1; pb.ready = 1;
        repeat (2) @(negedge clk);
        // reset state
        chk("rst_busy", busy_a, 0);
        chk("rst_done", done_a, 0);
        chk("rst_clk_en", ram_clk_en_a, 0);
        chk("rst_valid", pa.valid, 0);
        chk("rst_flags", {pa.sof, pa.eol, pa.eof}, 0);
        chk("rst_addr_a", ram_addr_a, 0);
        chk("rst_addr_b", ram_addr_b, 16382);
        @(posedge clk); #2 rst_n = 1;

        // T1: full-speed frame, literal timing from the start edge
        pulse_start_a();
        for (k = 0; k < 12; k++) begin
            @(negedge clk);
`ifdef RAM_PDP_READER_SCALE2X_EN
            exp_v = (k >= 3);
            chk("t1_valid", pa.valid, exp_v);
            if (exp_v) begin
                chk("t1_data", pa.data, (k - 3 < 8) ? (k - 3) / 2 : (k - 11) / 2);
                chk("t1_sof", pa.sof, k == 3);
                chk("t1_eol", pa.eol, k == 10);
            end
`else
            exp_v = (k >= 3 && k <= 10);
            chk("t1_valid", pa.valid, exp_v);
            if (exp_v) begin
                chk("t1_data", pa.data, k - 3);
                chk("t1_sof", pa.sof, k == 3);
                chk("t1_eol", pa.eol, k == 6 || k == 10);
                chk("t1_eof", pa.eof, k == 10);
            end
            chk("t1_done", done_a, k == 11);
`endif
        end
        wait_idle_a("t1_idle_timeout");

        // T2: m_ready toggling 1-0-1-0
        pulse_start_a();
        n_x = 0; n_done = 0;
        for (int c = 0; c < 300 && n_done == 0; c++) begin
            pa.ready = (c % 2 == 0);
            @(negedge clk);
            if (pa.valid && pa.ready) n_x++;
            if (done_a) n_done++;
            @(posedge clk); #2;
        end
        pa.ready = 1;
        chk("t2_pixels", n_x, A_PIX);
        chk("t2_done_pulses", n_done, 1);

        // T3: start repeated mid-frame is ignored
        pulse_start_a();
        n_x = 0; n_done = 0;
        for (int c = 0; c < 80; c++) begin
            start_a = (c == 4);
            @(negedge clk);
            if (pa.valid && pa.ready) n_x++;
            if (done_a) n_done++;
            @(posedge clk); #2;
        end
        start_a = 0;
        chk("t3_pixels", n_x, A_PIX);
        chk("t3_done_pulses", n_done, 1);

        // T4: reset after three transfers, then a clean frame
        pulse_start_a();
        n_x = 0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (pa.valid && pa.ready) n_x++;
            if (n_x == 3) break;
            @(posedge clk); #2;
        end
        chk("t4_three_transfers", n_x, 3);
        @(posedge clk); #2 rst_n = 0;
        #1;
        chk("t4_valid_async", pa.valid, 0);
        chk("t4_busy_async", busy_a, 0);
        chk("t4_clk_en_async", ram_clk_en_a, 0);
        chk("t4_addr_async", ram_addr_a, 0);
        @(posedge clk); #2 rst_n = 1;
        pulse_start_a();
        for (k = 0; k < 4; k++) @(negedge clk);
        chk("t4_restart_valid", pa.valid, 1);
        chk("t4_restart_data", pa.data, 0);
        chk("t4_restart_sof", pa.sof, 1);
        wait_idle_a("t4_idle_timeout");

        // T5: instance B, base address wraps past 2^14
`ifdef RAM_PDP_READER_SCALE2X_EN
        b_lit = '{16382, 16382, 16383, 16383, 0, 0, 1, 1};
        b_nlit = 8;
`else
        b_lit = '{16382, 16383, 0, 1, 0, 0, 0, 0};
        b_nlit = 4;
`endif
        @(posedge clk); #2 start_b = 1;
        @(posedge clk); #2 start_b = 0;
        bi = 0; n_done = 0;
        for (int c = 0; c < 200 && n_done == 0; c++) begin
            @(negedge clk);
            if (pb.valid && pb.ready) begin
                e = exp_pix(16382, 4, 1, bi);
                chk("b_data", pb.data, e[20:3]);
                chk("b_flags", {pb.sof, pb.eol, pb.eof}, e[2:0]);
                if (bi < b_nlit) chk("b_data_literal", pb.data, b_lit[bi]);
                bi++;
            end
            if (done_b) n_done++;
        end
        chk("b_pixels", bi, B_PIX);
        chk("b_done_seen", n_done, 1);
        chk("b_addr_end", ram_addr_b, 2);
        chk("b_busy_end", busy_b, 0);

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
